axi_full_master_sequencer: RTL and testbench
============================================

AXI_FULL_MASTER_SEQUENCER -- requirements
Module: axi_full_master_sequencer

Interface
REQ-001 Parameter C_M_AXI_ID_WIDTH, default 1, AWID/ARID width; SHALL drive all-zero IDs.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, W/R data width; WSTRB width SHALL be C_M_AXI_DATA_WIDTH/8.
REQ-003 Parameter C_M_AXI_ADDR_WIDTH, default 6, AW/AR address width.
REQ-004 Parameter C_M_TARGET_BASE_ADDR, default 0, address driven on AWADDR and ARADDR.
REQ-005 M_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 M_AXI_ARESETN  in  1  synchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; launches one write-burst-then-read-burst transaction pair.
REQ-008 burst_len  in  8  AXI LEN encoding (beats-1), sampled on accepted start.
REQ-009 busy / done / error  out  1 each  busy during sequence; done one-cycle pulse at end; error sticky.
REQ-010 M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID out, AWREADY in: AXI4 write address channel.
REQ-011 M_AXI_WDATA/WSTRB/WLAST/WVALID out, WREADY in: AXI4 write data channel.
REQ-012 M_AXI_BID/BRESP/BVALID in, BREADY out: AXI4 write response channel.
REQ-013 M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out, ARREADY in: AXI4 read address channel.
REQ-014 M_AXI_RID/RDATA/RRESP/RLAST/RVALID in, RREADY out: AXI4 read data channel.
REQ-015 AWSIZE/ARSIZE SHALL equal log2(C_M_AXI_DATA_WIDTH/8); AWBURST/ARBURST SHALL be 2'b01 (INCR); WSTRB all ones; lock/cache/prot/qos outputs SHALL NOT exist.

Function
REQ-016 FSM states SHALL be IDLE, AW, W, B, AR, R, DONE.
REQ-017 IDLE: start=1 SHALL latch burst_len into len_q and enter AW next cycle; start outside IDLE SHALL be ignored.
REQ-018 AW: AWVALID=1, AWLEN=len_q; on AWVALID&AWREADY SHALL enter W.
REQ-019 W: WVALID=1; beat counter SHALL start at 0, WDATA = counter+1 zero-extended; counter increments on WVALID&WREADY.
REQ-020 WLAST SHALL be 1 exactly when counter==len_q; handshake with WLAST SHALL enter B.
REQ-021 B: BREADY=1; on BVALID SHALL set error if BRESP!=2'b00, then enter AR.
REQ-022 AR: ARVALID=1, ARLEN=len_q; on ARVALID&ARREADY SHALL clear beat counter and enter R.
REQ-023 R: RREADY=1; each RVALID beat SHALL increment counter; RRESP!=2'b00 SHALL set error.
REQ-024 R SHALL exit to DONE on RVALID&RLAST, or on the (len_q+1)-th beat, whichever first; RLAST arriving on a different beat than counter==len_q SHALL set error.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-026 VALID outputs SHALL stay asserted with stable payload until handshake; no combinational path from any READY to any VALID.
REQ-027 len_q=0 (single beat) SHALL assert WLAST on the first W beat; len_q=255 counter SHALL be 8 bits without wrap before exit.
REQ-028 error SHALL clear only on reset or on the next accepted start.

Reset
REQ-029 While M_AXI_ARESETN=0 at a clock edge: state=IDLE, counter=0, len_q=0, all VALIDs/READYs=0, busy=0, done=0, error=0.
REQ-030 Reset asserted mid-sequence SHALL abandon the transaction with no further handshakes.

Configuration
REQ-031 Macro AXI_SEQ_READ_CHECK_EN defined: each R beat SHALL compare RDATA with counter+1 and set error on mismatch.
REQ-032 Macro undefined: RDATA SHALL be ignored; error from BRESP, RRESP and RLAST position only.

Verification
REQ-033 burst_len=3, slave always ready, RDATA 1..4 -> WDATA 1,2,3,4, WLAST on beat 4, done pulse, error=0.
REQ-034 burst_len=0 -> single W beat WDATA=1 with WLAST, single R beat, done, error=0.
REQ-035 WREADY toggled 1,0,0,1 over beats -> WDATA/WLAST held stable while stalled, 4 beats total.
REQ-036 BRESP=2'b10 -> error=1 after B, read phase still runs, done pulses, error held until next start.
REQ-037 With AXI_SEQ_READ_CHECK_EN, RDATA beat 2 = 7 -> error=1; without macro -> error=0.
REQ-038 Reset pulse during W beat 2 -> all outputs zero next cycle; new start completes cleanly.

Source files
------------

// File: rtl/axi_full_master_sequencer.sv
// AXI4 master that runs one INCR write burst followed by one INCR read burst per start pulse.
// Optional macro AXI_SEQ_READ_CHECK_EN: compare each read beat with the written pattern (counter+1).
module axi_full_master_sequencer #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = '0
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            start,
  input  logic [7:0]                      burst_len,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic [2:0]                      dbg_state,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3,
    S_AR = 3'd4, S_R = 3'd5, S_DONE = 3'd6
  } state_t;

  localparam logic [2:0] AXI_SIZE = 3'($clog2(C_M_AXI_DATA_WIDTH/8));

  // Handshake rule: a VALID is a pure decode of state_q, so it never depends on READY
  // and its payload (len_q / cnt_q) only changes on the handshaking edge.
  state_t                        state_q, state_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          error_q, error_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] beat_data;
  logic                          last_beat;
  logic                          unused_inputs;

  assign beat_data     = C_M_AXI_DATA_WIDTH'(cnt_q) + C_M_AXI_DATA_WIDTH'(1);
  assign last_beat     = (cnt_q == len_q);
  assign unused_inputs = &{1'b0, M_AXI_BID, M_AXI_RID, M_AXI_RDATA};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (start) begin
        len_d   = burst_len;
        cnt_d   = 8'd0;
        error_d = 1'b0;
        state_d = S_AW;
      end
      S_AW: if (M_AXI_AWREADY) begin
        cnt_d   = 8'd0;
        state_d = S_W;
      end
      S_W: if (M_AXI_WREADY) begin
        cnt_d = cnt_q + 8'd1;
        if (last_beat) state_d = S_B;
      end
      S_B: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != 2'b00) error_d = 1'b1;
        state_d = S_AR;
      end
      S_AR: if (M_AXI_ARREADY) begin
        cnt_d   = 8'd0;
        state_d = S_R;
      end
      S_R: if (M_AXI_RVALID) begin
        cnt_d = cnt_q + 8'd1;
        if (M_AXI_RRESP != 2'b00) error_d = 1'b1;
        if (M_AXI_RLAST != last_beat) error_d = 1'b1;
`ifdef AXI_SEQ_READ_CHECK_EN
        if (M_AXI_RDATA != beat_data) error_d = 1'b1;
`endif
        if (M_AXI_RLAST || last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign dbg_state = state_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_TARGET_BASE_ADDR;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_AWSIZE  = AXI_SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state_q == S_AW);

  assign M_AXI_WVALID  = (state_q == S_W);
  assign M_AXI_WDATA   = M_AXI_WVALID ? beat_data : '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = M_AXI_WVALID && last_beat;

  assign M_AXI_BREADY  = (state_q == S_B);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_TARGET_BASE_ADDR;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = AXI_SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = (state_q == S_AR);

  assign M_AXI_RREADY  = (state_q == S_R);

endmodule

// File: tb/tb_axi_full_master_sequencer.sv
// Directed bench: drives the slave side cycle by cycle on the falling edge and checks every beat.
module tb_axi_full_master_sequencer;

  localparam logic [5:0] BASE = 6'h20;
`ifdef AXI_SEQ_READ_CHECK_EN
  localparam bit RD_CHECK = 1'b1;
`else
  localparam bit RD_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy, done, error;
  logic [2:0]  dbg_state;
  logic [0:0]  awid, arid;
  logic [5:0]  awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
  logic        rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'd0;
  logic [0:0]  bid = 1'b0, rid = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_full_master_sequencer #(
    .C_M_AXI_ID_WIDTH(1), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(6),
    .C_M_TARGET_BASE_ADDR(BASE)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_state"},   32'(dbg_state), 32'd0);
    check({pfx, "_busy"},    32'(busy),    32'd0);
    check({pfx, "_done"},    32'(done),    32'd0);
    check({pfx, "_error"},   32'(error),   32'd0);
    check({pfx, "_awvalid"}, 32'(awvalid), 32'd0);
    check({pfx, "_wvalid"},  32'(wvalid),  32'd0);
    check({pfx, "_wdata"},   wdata,        32'd0);
    check({pfx, "_wlast"},   32'(wlast),   32'd0);
    check({pfx, "_bready"},  32'(bready),  32'd0);
    check({pfx, "_arvalid"}, 32'(arvalid), 32'd0);
    check({pfx, "_rready"},  32'(rready),  32'd0);
    check({pfx, "_awlen"},   32'(awlen),   32'd0);
  endtask

  // One write-then-read pair. mask bit (cycle%16) gives WREADY; rlast_beat is the 0-based R beat
  // carrying RLAST; bad_beat (or -1) is the R beat whose data is replaced by bad_val.
  task automatic run_txn(input logic [7:0] len, input logic [15:0] mask, input logic [1:0] br,
                         input int rlast_beat, input int bad_beat, input logic [31:0] bad_val);
    int  beat;
    int  cyc;
    int  n_rbeats;
    bit  exp_err;
    bit  wr;
    n_rbeats = (rlast_beat < int'(len)) ? rlast_beat + 1 : int'(len) + 1;
    exp_err  = (br != 2'b00) || (rlast_beat != int'(len)) ||
               (RD_CHECK && bad_beat >= 0 && bad_beat < n_rbeats);
    start = 1'b1; burst_len = len;
    @(negedge clk);
    check("aw_valid", 32'(awvalid), 32'd1);
    check("aw_len",   32'(awlen),   32'(len));
    check("aw_addr",  32'(awaddr),  32'(BASE));
    check("aw_size",  32'(awsize),  32'd2);
    check("aw_burst", 32'(awburst), 32'd1);
    check("aw_id",    32'(awid),    32'd0);
    check("start_clears_error", 32'(error), 32'd0);
    check("busy", 32'(busy), 32'd1);
    burst_len = ~len;  // start while busy must be ignored
    awready = 1'b1;
    @(negedge clk);
    start = 1'b0; awready = 1'b0;
    check("w_strb", 32'(wstrb), 32'hF);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 1000) begin
      wr = mask[cyc % 16];
      wready = wr;
      check("w_valid", 32'(wvalid), 32'd1);
      check("w_data",  wdata, 32'(beat + 1));
      check("w_last",  32'(wlast), 32'(beat == int'(len)));
      @(negedge clk);
      if (wr) beat++;
      cyc++;
    end
    wready = 1'b0;
    if (beat <= int'(len)) check("w_timeout", 32'(beat), 32'(int'(len) + 1));
    check("w_done_valid", 32'(wvalid), 32'd0);
    check("b_ready", 32'(bready), 32'd1);
    bvalid = 1'b1; bresp = br;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    check("b_error", 32'(error), 32'(br != 2'b00));
    check("ar_valid", 32'(arvalid), 32'd1);
    check("ar_len",   32'(arlen),   32'(len));
    check("ar_addr",  32'(araddr),  32'(BASE));
    check("ar_size",  32'(arsize),  32'd2);
    check("ar_burst", 32'(arburst), 32'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      rvalid = 1'b1;
      rlast  = (i == rlast_beat);
      rdata  = (i == bad_beat) ? bad_val : 32'(i + 1);
      check("r_ready", 32'(rready), 32'd1);
      @(negedge clk);
      if (i == rlast_beat) break;
    end
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    check("r_done_ready", 32'(rready), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy",  32'(busy), 32'd1);
    @(negedge clk);
    check("done_low",  32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("final_error", 32'(error), 32'(exp_err));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    run_txn(8'd3, 16'hFFFF, 2'b00, 3, -1, 32'd0);
    run_txn(8'd0, 16'hFFFF, 2'b00, 0, -1, 32'd0);
    run_txn(8'd3, 16'h9999, 2'b00, 3, -1, 32'd0);
    run_txn(8'd3, 16'hFFFF, 2'b10, 3, -1, 32'd0);
    repeat (4) @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    run_txn(8'd3, 16'hFFFF, 2'b00, 3, 1, 32'd7);
    run_txn(8'd3, 16'hFFFF, 2'b00, 1, -1, 32'd0);
    run_txn(8'd255, 16'hFFFF, 2'b00, 255, -1, 32'd0);

    // reset during the second W beat
    start = 1'b1; burst_len = 8'd3;
    @(negedge clk);
    start = 1'b0; awready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b1;
    check("rst_w_beat1", wdata, 32'd1);
    @(negedge clk);
    check("rst_w_beat2", wdata, 32'd2);
    rstn = 1'b0;
    @(negedge clk);
    wready = 1'b0;
    check_quiet("midrst");
    @(negedge clk);
    check_quiet("midrst_hold");
    rstn = 1'b1;
    @(negedge clk);
    run_txn(8'd2, 16'hFFFF, 2'b00, 2, -1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
